// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: RV32 opcode map, sequencer states, the MEM/WB occupancy record
// and the opcode classification helpers shared by hazard_ctrl and haz_op_class.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        RAW_STALL = 2'd2
    } state_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       mem;
    } wb_rec_t;

    typedef struct packed {
        logic writes_rd;
        logic uses_rs1;
        logic uses_rs2;
        logic is_mem;
    } op_class_t;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_I_ALU, OP_LOAD, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_SYSTEM: writes_rd = 1'b1;
            default:                    writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_I_ALU, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JALR, OP_SYSTEM: uses_rs1 = 1'b1;
            default:                       uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default:                   uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: is_mem = 1'b1;
            default:           is_mem = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decoded DE/EX fields, memory handshake and pipeline control
// outputs; master is the core datapath, slave is the hazard sequencer.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             ex_br_taken;
    logic             mem_ready;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             bubble_wb;
    logic             fwd_a;
    logic             fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_br_taken, mem_ready,
        input  stall_if, stall_id, flush_id, bubble_wb, fwd_a, fwd_b, mem_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_br_taken, mem_ready,
        output stall_if, stall_id, flush_id, bubble_wb, fwd_a, fwd_b, mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_op_class.sv
// haz_op_class: combinational opcode classifier for the DE/EX instruction.
module haz_op_class
    import hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    // Classify the opcode into register-usage and memory-access flags.
    always_comb begin
        cls.writes_rd = writes_rd(opcode);
        cls.uses_rs1  = uses_rs1(opcode);
        cls.uses_rs2  = uses_rs2(opcode);
        cls.is_mem    = is_mem(opcode);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble/forward sequencer for the IF -> DE/EX -> MEM/WB core.
// Optional feature macro HAZ_FWD_EN: forward from MEM/WB instead of stalling on RAW deps.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e            state_r;
    state_e            state_next_s;
    wb_rec_t           rec_r;
    wb_rec_t           rec_next_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;
    logic              err_next_s;

    op_class_t         cls_s;
    logic              dep_a_s;
    logic              dep_b_s;
    logic              mem_hold_s;
    logic              raw_stall_s;
    logic              stall_s;
    logic              timeout_s;

    haz_op_class u_op_class (
        .opcode (bus.id_opcode),
        .cls    (cls_s)
    );

    // Hazard detection against the MEM/WB occupant and the resulting stall decision.
    always_comb begin
        dep_a_s    = rec_r.v & rec_r.wr & (rec_r.rd == bus.id_rs1) & bus.id_valid & cls_s.uses_rs1;
        dep_b_s    = rec_r.v & rec_r.wr & (rec_r.rd == bus.id_rs2) & bus.id_valid & cls_s.uses_rs2;
        mem_hold_s = (state_r == MEM_WAIT) & rec_r.v & rec_r.mem & ~bus.mem_ready;
`ifdef HAZ_FWD_EN
        raw_stall_s = 1'b0;
`else
        // Without forwarding a dep only costs a cycle once the memory access is done.
        raw_stall_s = (dep_a_s | dep_b_s) & ~mem_hold_s;
`endif
        stall_s    = mem_hold_s | raw_stall_s;
        timeout_s  = mem_hold_s & (MEM_TIMEOUT != 0) & (wait_r == WAIT_W'(MEM_TIMEOUT - 1));
    end

    // Pipeline control outputs, combinational from current state and inputs.
    always_comb begin
        bus.stall_if  = stall_s;
        bus.stall_id  = stall_s;
        bus.bubble_wb = raw_stall_s;
        bus.flush_id  = bus.ex_br_taken & ~stall_s;
`ifdef HAZ_FWD_EN
        bus.fwd_a     = dep_a_s & ~stall_s;
        bus.fwd_b     = dep_b_s & ~stall_s;
`else
        bus.fwd_a     = 1'b0;
        bus.fwd_b     = 1'b0;
`endif
        bus.mem_err   = err_r;
        bus.stall_cnt = cnt_r;
    end

    // Next-state, MEM/WB record and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        rec_next_s   = rec_r;
        wait_next_s  = wait_r;
        err_next_s   = err_r;
        case (state_r)
            RUN, RAW_STALL, MEM_WAIT: begin
                if (mem_hold_s) begin
                    if (timeout_s) begin
                        rec_next_s.v = 1'b0;
                        wait_next_s  = '0;
                        err_next_s   = 1'b1;
                        state_next_s = RUN;
                    end else begin
                        wait_next_s  = wait_r + WAIT_W'(1);
                        state_next_s = MEM_WAIT;
                    end
                end else begin
                    rec_next_s.v   = bus.id_valid & ~raw_stall_s;
                    rec_next_s.rd  = bus.id_rd;
                    rec_next_s.wr  = cls_s.writes_rd & (bus.id_rd != 5'd0);
                    rec_next_s.mem = cls_s.is_mem;
                    wait_next_s    = '0;
                    if (bus.id_valid && !raw_stall_s && cls_s.is_mem) begin
                        state_next_s = MEM_WAIT;
                    end else if (raw_stall_s) begin
                        state_next_s = RAW_STALL;
                    end else begin
                        state_next_s = RUN;
                    end
                end
            end
            default: begin
                state_next_s = RUN;
                rec_next_s   = '0;
                wait_next_s  = '0;
            end
        endcase
    end

    // State, record, error flag and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RUN;
            rec_r   <= '0;
            wait_r  <= '0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            rec_r   <= rec_next_s;
            wait_r  <= wait_next_s;
            err_r   <= err_next_s;
            if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against an occupancy-based
// reference model of the MEM/WB slot; works with or without HAZ_FWD_EN.
module tb_hazard_ctrl;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_IALU  = 7'b0010011;
    localparam logic [6:0] T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_BR    = 7'b1100011;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_SYS   = 7'b1110011;
    localparam logic [6:0] T_FENCE = 7'b0001111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Model: what instruction sits in MEM/WB and how long it has waited on memory.
    bit         m_v = 1'b0;
    logic [4:0] m_rd = 5'd0;
    bit         m_wr = 1'b0;
    bit         m_mem = 1'b0;
    int         m_waited = 0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {writes rd, reads rs1, reads rs2, memory access}
    function automatic logic [3:0] op_info(input logic [6:0] op);
        case (op)
            T_R:     return 4'b1110;
            T_IALU:  return 4'b1100;
            T_LOAD:  return 4'b1101;
            T_STORE: return 4'b0111;
            T_BR:    return 4'b0110;
            T_LUI:   return 4'b1000;
            T_AUIPC: return 4'b1000;
            T_JAL:   return 4'b1000;
            T_JALR:  return 4'b1100;
            T_SYS:   return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [3:0] info;
        bit dep_a, dep_b, waiting, stall, bubble;
        if (chk_on) begin
            info    = op_info(bus.id_opcode);
            dep_a   = m_v && m_wr && (m_rd == bus.id_rs1) && bus.id_valid && info[2];
            dep_b   = m_v && m_wr && (m_rd == bus.id_rs2) && bus.id_valid && info[1];
            waiting = m_v && m_mem && !bus.mem_ready;
            stall   = waiting || (!FWD && (dep_a || dep_b));
            bubble  = stall && !waiting;
            cmp("m_stall_if",  32'(bus.stall_if),  32'(stall));
            cmp("m_stall_id",  32'(bus.stall_id),  32'(stall));
            cmp("m_bubble_wb", 32'(bus.bubble_wb), 32'(bubble));
            cmp("m_flush_id",  32'(bus.flush_id),  32'(bus.ex_br_taken && !stall));
            cmp("m_fwd_a",     32'(bus.fwd_a),     32'(FWD && dep_a && !stall));
            cmp("m_fwd_b",     32'(bus.fwd_b),     32'(FWD && dep_b && !stall));
            cmp("m_mem_err",   32'(bus.mem_err),   32'(m_err));
            cmp("m_stall_cnt", 32'(bus.stall_cnt), 32'((m_cnt > CNT_MAX) ? CNT_MAX : m_cnt));
            if (!rst_n) begin
                m_v = 1'b0; m_rd = 5'd0; m_wr = 1'b0; m_mem = 1'b0;
                m_waited = 0; m_err = 1'b0; m_cnt = 0;
            end else begin
                if (stall) m_cnt++;
                if (waiting) begin
                    m_waited++;
                    if (MEM_TIMEOUT != 0 && m_waited >= MEM_TIMEOUT) begin
                        m_err = 1'b1;
                        m_v   = 1'b0;
                    end
                end else begin
                    m_v      = bus.id_valid && !bubble;
                    m_rd     = bus.id_rd;
                    m_wr     = info[3] && (bus.id_rd != 5'd0);
                    m_mem    = info[0];
                    m_waited = 0;
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input bit br, input bit rdy);
        bus.id_valid    = v;
        bus.id_opcode   = op;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.ex_br_taken = br;
        bus.mem_ready   = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [12];

    initial begin
        ops = '{T_R, T_IALU, T_LOAD, T_STORE, T_BR, T_LUI, T_AUIPC, T_JAL, T_JALR, T_SYS, T_FENCE, 7'd0};
        idle();
        tick();
        chk_on = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        cmp("reset_stall_id", 32'(bus.stall_id), 32'd0);
        cmp("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        cmp("reset_mem_err", 32'(bus.mem_err), 32'd0);

        // addi x5 then add x6,x5,x1
        do_reset();
        drive(1'b1, T_IALU, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
        @(negedge clk); cmp("t1_addi_no_stall", 32'(bus.stall_id), 32'd0);
        tick();
        drive(1'b1, T_R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
        @(negedge clk);
        cmp("t1_dep_stall_id", 32'(bus.stall_id), 32'(!FWD));
        cmp("t1_dep_stall_if", 32'(bus.stall_if), 32'(!FWD));
        cmp("t1_dep_bubble", 32'(bus.bubble_wb), 32'(!FWD));
        cmp("t2_fwd_a", 32'(bus.fwd_a), 32'(FWD));
        cmp("t2_fwd_b", 32'(bus.fwd_b), 32'd0);
        tick();
        @(negedge clk); cmp("t1_second_cycle", 32'(bus.stall_id), 32'd0);
        tick();
        idle();
        @(negedge clk); cmp("t1_stall_cnt", 32'(bus.stall_cnt), 32'(!FWD));

        // x0 writer then x0 reader
        tick();
        drive(1'b1, T_IALU, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, T_R, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        cmp("t8_x0_stall", 32'(bus.stall_id), 32'd0);
        cmp("t8_x0_fwd_a", 32'(bus.fwd_a), 32'd0);
        cmp("t8_x0_fwd_b", 32'(bus.fwd_b), 32'd0);

        // taken branch without stall
        tick();
        drive(1'b1, T_BR, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
        @(negedge clk); cmp("t4_flush", 32'(bus.flush_id), 32'd1);
        tick();
        idle();
        @(negedge clk); cmp("t4_flush_one_cycle", 32'(bus.flush_id), 32'd0);

        // lw x7 with three wait cycles
        do_reset();
        drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, T_R, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("t3_wait_stall_if", 32'(bus.stall_if), 32'd1);
            cmp("t3_wait_stall_id", 32'(bus.stall_id), 32'd1);
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk); cmp("t3_ready_release", 32'(bus.stall_id), 32'd0);
        tick();
        idle();
        @(negedge clk);
        cmp("t3_stall_cnt", 32'(bus.stall_cnt), 32'd3);
        cmp("t3_back_to_run", 32'(bus.stall_id), 32'd0);

        // taken branch during memory wait
        do_reset();
        drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, T_BR, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        cmp("t5_flush_blocked", 32'(bus.flush_id), 32'd0);
        cmp("t5_stalled", 32'(bus.stall_id), 32'd1);
        tick();
        bus.mem_ready = 1'b1;
        @(negedge clk); cmp("t5_flush_after_ready", 32'(bus.flush_id), 32'd1);

        // memory timeout
        do_reset();
        drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, T_R, 5'd7, 5'd7, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clk);
            cmp("t6_wait_stall", 32'(bus.stall_id), 32'd1);
            cmp("t6_no_err_yet", 32'(bus.mem_err), 32'd0);
            tick();
        end
        @(negedge clk);
        cmp("t6_mem_err", 32'(bus.mem_err), 32'd1);
        cmp("t6_dropped_no_stall", 32'(bus.stall_id), 32'd0);
        cmp("t6_dropped_no_fwd", 32'(bus.fwd_a), 32'd0);
        cmp("t6_stall_cnt", 32'(bus.stall_cnt), 32'(MEM_TIMEOUT));

        // reset in the middle of a memory wait
        do_reset();
        drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, T_R, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        @(negedge clk); cmp("t7_pre_reset_stall", 32'(bus.stall_id), 32'd1);
        tick();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        cmp("t7_stall_if", 32'(bus.stall_if), 32'd0);
        cmp("t7_stall_id", 32'(bus.stall_id), 32'd0);
        cmp("t7_flush_id", 32'(bus.flush_id), 32'd0);
        cmp("t7_bubble_wb", 32'(bus.bubble_wb), 32'd0);
        cmp("t7_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'd0);
        cmp("t7_mem_err", 32'(bus.mem_err), 32'd0);
        cmp("t7_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // counter saturation: 70 timed-out loads, 4 stall cycles each
        do_reset();
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, T_LOAD, 5'd2, 5'd0, 5'd7, 1'b0, 1'b1);
            tick();
            drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            repeat (MEM_TIMEOUT) tick();
        end
        idle();
        @(negedge clk);
        cmp("sat_stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));
        cmp("sat_mem_err", 32'(bus.mem_err), 32'd1);

        // randomized traffic, checked every cycle by the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 255) != 0);
            drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 11)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
